// File: rtl/render_write_arbiter_if.sv
// Engine-side and MCB-side signal bundle of the render write arbiter.
// The arbiter connects through the slave modport; engines and the MCB drive master.
interface render_write_arbiter_if #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned WADDR_W     = 21
);
  logic                                  mem_calib_done;
  logic [NUM_ENGINES-1:0]                eng_req;
  logic [NUM_ENGINES-1:0][WADDR_W-1:0]   eng_addr;
  logic [NUM_ENGINES-1:0][31:0]          eng_data;
  logic [NUM_ENGINES-1:0]                eng_valid;
  logic [NUM_ENGINES-1:0]                eng_last;
  logic [NUM_ENGINES-1:0]                eng_ready;
  logic [NUM_ENGINES-1:0]                eng_grant;
  logic [NUM_ENGINES-1:0]                eng_frame_done;
  logic                                  wr_full;
  logic                                  wr_en;
  logic [31:0]                           wr_data;
  logic [3:0]                            wr_mask;
  logic                                  cmd_full;
  logic                                  cmd_en;
  logic [2:0]                            cmd_instr;
  logic [5:0]                            cmd_bl;
  logic [29:0]                           cmd_byte_addr;
  logic                                  display_frame;
  logic                                  frame_swap;

  modport slave (
    input  mem_calib_done, eng_req, eng_addr, eng_data, eng_valid, eng_last, eng_frame_done,
    input  wr_full, cmd_full,
    output eng_ready, eng_grant, wr_en, wr_data, wr_mask,
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, display_frame, frame_swap
  );

  modport master (
    output mem_calib_done, eng_req, eng_addr, eng_data, eng_valid, eng_last, eng_frame_done,
    output wr_full, cmd_full,
    input  eng_ready, eng_grant, wr_en, wr_data, wr_mask,
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, display_frame, frame_swap
  );
endinterface

// File: rtl/render_write_arbiter.sv
// Round-robin burst arbiter from N rendering engines onto one MCB write port, issuing one
// WRITE command per burst and owning the double-buffered display/write frame selector.
module render_write_arbiter #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned WADDR_W     = 21,
  parameter logic [29:0] FRAME0_BASE = 30'h0000000,
  parameter logic [29:0] FRAME1_BASE = 30'h0800000
) (
  input  logic                  clk,
  input  logic                  resetn,
  render_write_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int unsigned CntW = 7;

  typedef enum logic [1:0] {StIdle, StXfer, StCmd} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        rr_q, rr_d;
  logic [IdxW-1:0]        gidx_q, gidx_d;
  logic [NUM_ENGINES-1:0] grant_q, grant_d;
  logic [NUM_ENGINES-1:0] done_q, done_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [29:0]            addr_q, addr_d;
  logic                   display_q, display_d;
  logic                   swap_q, swap_d;

  logic                   found;
  logic [IdxW-1:0]        pick;
  logic [IdxW-1:0]        cand;
  logic [29:0]            wbase;
  logic                   xfer;
  logic                   burst_end;

  // The write frame is always the one not being displayed.
  assign wbase     = display_q ? FRAME0_BASE : FRAME1_BASE;
  assign xfer      = (state_q == StXfer) && bus.eng_valid[gidx_q] && !bus.wr_full;
  assign burst_end = bus.eng_last[gidx_q] || (count_q == CntW'(BURST_LEN - 1));

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < int'(NUM_ENGINES); k++) begin
      cand = IdxW'((int'(rr_q) + k) % int'(NUM_ENGINES));
      if (!found && bus.eng_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      display_q <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      display_q <= display_d;
      swap_q    <= swap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    count_d   = count_q;
    addr_d    = addr_q;
    display_d = display_q;
    swap_d    = 1'b0;
    done_d    = done_q | bus.eng_frame_done;
    unique case (state_q)
      StIdle: begin
        if (&done_q) begin
          // Pulses arriving this cycle seed the next frame's flags.
          display_d = ~display_q;
          swap_d    = 1'b1;
          done_d    = bus.eng_frame_done;
        end else if (bus.mem_calib_done && found) begin
          state_d       = StXfer;
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          count_d       = '0;
          addr_d        = wbase + 30'({bus.eng_addr[pick], 2'b00});
          rr_d          = (pick == IdxW'(NUM_ENGINES - 1)) ? '0 : pick + 1'b1;
        end
      end
      StXfer: begin
        if (xfer) begin
          count_d = count_q + 1'b1;
          if (burst_end) state_d = StCmd;
        end
      end
      StCmd: begin
        if (!bus.cmd_full) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.eng_grant     = grant_q;
    bus.eng_ready     = ((state_q == StXfer) && !bus.wr_full) ? grant_q : '0;
    bus.wr_en         = xfer;
    bus.wr_data       = (state_q == StXfer) ? bus.eng_data[gidx_q] : '0;
    bus.wr_mask       = 4'b0000;
    bus.cmd_instr     = 3'b000;
    bus.cmd_en        = (state_q == StCmd) && !bus.cmd_full;
    bus.cmd_bl        = (state_q == StCmd) ? 6'(count_q - 1'b1) : '0;
    bus.cmd_byte_addr = addr_q;
    bus.display_frame = display_q;
    bus.frame_swap    = swap_q;
  end

endmodule
